alarm_trigger: RTL
==================

// Module: alarm_trigger
// PURPOSE
//  Consumes the alarm-set digits (HH:MM, BCD-style split digits) and the running time digits.
//  Raises and times out the alarm output, with acknowledge and snooze.
//  Sits between the alarm-setting counters / time-keeping counters and the buzzer/LED drivers.
//  Runs on the divided 1 Hz tick clock, so one cycle = one second.
// PARAMETERS
//  RING_CYCLES    60   cycles alarm rings before auto-timeout (>=2)
//  SNOOZE_CYCLES  300  cycles spent in snooze before re-ringing (>=2)
// PORTS
//  clk_out        in   1  system clock (divided tick clock)
//  reset          in   1  asynchronous, active-high reset
//  alarm_en       in   1  alarm armed switch (level)
//  ack            in   1  stop alarm (level, sampled each cycle)
//  snooze         in   1  snooze request (level); ignored unless SNOOZE_EN
//  minutes_units  in   4  current time minutes units (0-9)
//  minutes_tens   in   3  current time minutes tens (0-5)
//  hours_units    in   4  current time hours units (0-9)
//  hours_tens     in   2  current time hours tens (0-2)
//  al_minutes_units in 4  alarm minutes units
//  al_minutes_tens  in 3  alarm minutes tens
//  al_hours_units   in 4  alarm hours units
//  al_hours_tens    in 2  alarm hours tens
//  alarm_on       out  1  buzzer drive, high while RINGING
//  alarm_led      out  1  toggles every cycle while RINGING, else 0
//  snoozing       out  1  high while in SNOOZE
// BEHAVIOUR
//  - match = all four time digits equal the four alarm digits (combinational compare).
//  - match_q = match registered; match_rise = match & ~match_q. Only a rising match triggers.
//    Hence no retrigger within the same matching minute after ack/timeout.
//  - Reset (async): state=IDLE, alarm_on=0, alarm_led=0, snoozing=0, counters=0, match_q=1.
//    match_q=1 at reset: a match already present at reset release does not fire.
//  - States: IDLE, ARMED, RINGING, SNOOZE. All outputs are registered from the next state.
//  - IDLE:    alarm_en=1 -> ARMED.
//  - ARMED:   alarm_en=0 -> IDLE; else match_rise -> RINGING, ring_cnt<=0.
//  - RINGING: priority alarm_en=0 -> IDLE > ack -> ARMED > snooze -> SNOOZE (snz_cnt<=0)
//             > ring_cnt==RING_CYCLES-1 -> ARMED; else ring_cnt++.
//  - SNOOZE:  priority alarm_en=0 -> IDLE > ack -> ARMED
//             > snz_cnt==SNOOZE_CYCLES-1 -> RINGING (ring_cnt<=0); else snz_cnt++.
//  - Latency: match_rise sampled at edge N -> alarm_on=1 after edge N.
//    Ringing lasts exactly RING_CYCLES cycles when undisturbed.
//  - alarm_led: 1 on the first RINGING cycle, inverts each cycle after; forced 0 on leaving RINGING.
//  - Counter widths: $clog2 of the respective parameter. Counters never exceed param-1.
//    Counters are cleared on every state entry.
//  - Reset mid-RINGING/SNOOZE: immediate return to reset values, with no alarm until next match_rise.
//  - Alarm digit change during RINGING: ringing continues (only entry depends on match).
// CONFIGURATION
//  SNOOZE_EN defined: snooze input active, SNOOZE state present, snoozing output driven.
//  SNOOZE_EN undefined: snooze input ignored, SNOOZE state unreachable/removed, snoozing tied 0.
//    RINGING ends only by alarm_en=0, ack, or timeout.
// TESTING (RING_CYCLES=4, SNOOZE_CYCLES=3)
//  1. alarm 07:30, en=1, time steps 07:29->07:30 -> alarm_on=1 next edge;
//     high exactly 4 cycles; alarm_led 1,0,1,0; then ARMED.
//  2. Ringing, ack=1 for 1 cycle at ring cycle 2 -> alarm_on=0 next edge.
//     Time held 07:30 -> no retrigger; 07:31 then 07:30 -> rings again.
//  3. SNOOZE_EN: snooze pulse while ringing -> snoozing=1, alarm_on=0 for 3 cycles -> rings 4 more cycles.
//  4. alarm_en=0 while ringing with ack=1, snooze=1 same cycle -> IDLE, all outputs 0;
//     match_rise in IDLE -> no ring.
//  5. time==alarm during reset, release reset with en=1 -> no ring.
//     Assert reset mid-ring -> outputs 0 asynchronously.
//  6. Without SNOOZE_EN: snooze=1 while ringing -> ignored, snoozing stays 0, ring times out after 4 cycles.

Source files
------------

// File: rtl/alarm_trigger_if.sv
// Alarm trigger bus: time digits, alarm digits, control levels and alarm outputs.
// The master side is the time-keeping/alarm-setting logic; the slave side is alarm_trigger.
interface alarm_trigger_if;

    // Control levels
    logic       alarm_en;
    logic       ack;
    logic       snooze;

    // Current time digits
    logic [3:0] minutes_units;
    logic [2:0] minutes_tens;
    logic [3:0] hours_units;
    logic [1:0] hours_tens;

    // Alarm-set digits
    logic [3:0] al_minutes_units;
    logic [2:0] al_minutes_tens;
    logic [3:0] al_hours_units;
    logic [1:0] al_hours_tens;

    // Alarm outputs
    logic       alarm_on;
    logic       alarm_led;
    logic       snoozing;

    modport master (
        output alarm_en, ack, snooze,
        output minutes_units, minutes_tens, hours_units, hours_tens,
        output al_minutes_units, al_minutes_tens, al_hours_units, al_hours_tens,
        input  alarm_on, alarm_led, snoozing
    );

    modport slave (
        input  alarm_en, ack, snooze,
        input  minutes_units, minutes_tens, hours_units, hours_tens,
        input  al_minutes_units, al_minutes_tens, al_hours_units, al_hours_tens,
        output alarm_on, alarm_led, snoozing
    );

endinterface

// File: rtl/alarm_trigger.sv
// alarm_trigger: raises the buzzer when the running time reaches the alarm time,
// times the ring out, and handles acknowledge (and snooze when SNOOZE_EN is defined).
// One clock cycle equals one second (divided tick clock).
// Optional feature macro: SNOOZE_EN (adds the SNOOZE state and drives snoozing).
module alarm_trigger #(
    parameter int unsigned RING_CYCLES   = 60,
    parameter int unsigned SNOOZE_CYCLES = 300
) (
    input  logic           clk_out,
    input  logic           reset,
    alarm_trigger_if.slave bus
);

    localparam int unsigned RING_W = $clog2(RING_CYCLES);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        RINGING = 2'd2,
        SNOOZE  = 2'd3
    } state_e;

    state_e              state_q;
    logic [RING_W-1:0]   ring_cnt_q;
    logic                match;
    logic                match_q;
    logic                match_rise;
    logic                alarm_on_q;
    logic                alarm_led_q;

`ifdef SNOOZE_EN
    localparam int unsigned SNZ_W = $clog2(SNOOZE_CYCLES);
    logic [SNZ_W-1:0]    snz_cnt_q;
    logic                snoozing_q;
`else
    // Snooze input and period have no effect in this build.
    localparam int unsigned unused_snooze_cycles = SNOOZE_CYCLES;
    logic                unused_snooze;
    assign unused_snooze = bus.snooze;
`endif

    // Time equals alarm time on all four digits; only a rising match triggers.
    assign match = (bus.minutes_units == bus.al_minutes_units) &&
                   (bus.minutes_tens  == bus.al_minutes_tens)  &&
                   (bus.hours_units   == bus.al_hours_units)   &&
                   (bus.hours_tens    == bus.al_hours_tens);
    assign match_rise = match & ~match_q;

    // Alarm FSM with counters and outputs registered from the next state.
    always_ff @(posedge clk_out or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            ring_cnt_q  <= '0;
            match_q     <= 1'b1;
            alarm_on_q  <= 1'b0;
            alarm_led_q <= 1'b0;
`ifdef SNOOZE_EN
            snz_cnt_q   <= '0;
            snoozing_q  <= 1'b0;
`endif
        end else begin
            match_q <= match;
            case (state_q)
                IDLE: begin
                    if (bus.alarm_en) begin
                        state_q    <= ARMED;
                        ring_cnt_q <= '0;
                    end
                end
                ARMED: begin
                    if (!bus.alarm_en) begin
                        state_q    <= IDLE;
                        ring_cnt_q <= '0;
                    end else if (match_rise) begin
                        state_q     <= RINGING;
                        ring_cnt_q  <= '0;
                        alarm_on_q  <= 1'b1;
                        alarm_led_q <= 1'b1;
                    end
                end
                RINGING: begin
                    if (!bus.alarm_en) begin
                        state_q     <= IDLE;
                        ring_cnt_q  <= '0;
                        alarm_on_q  <= 1'b0;
                        alarm_led_q <= 1'b0;
                    end else if (bus.ack) begin
                        state_q     <= ARMED;
                        ring_cnt_q  <= '0;
                        alarm_on_q  <= 1'b0;
                        alarm_led_q <= 1'b0;
`ifdef SNOOZE_EN
                    end else if (bus.snooze) begin
                        state_q     <= SNOOZE;
                        ring_cnt_q  <= '0;
                        snz_cnt_q   <= '0;
                        alarm_on_q  <= 1'b0;
                        alarm_led_q <= 1'b0;
                        snoozing_q  <= 1'b1;
`endif
                    end else if (ring_cnt_q == RING_W'(RING_CYCLES - 1)) begin
                        state_q     <= ARMED;
                        ring_cnt_q  <= '0;
                        alarm_on_q  <= 1'b0;
                        alarm_led_q <= 1'b0;
                    end else begin
                        ring_cnt_q  <= ring_cnt_q + RING_W'(1);
                        alarm_led_q <= ~alarm_led_q;
                    end
                end
`ifdef SNOOZE_EN
                SNOOZE: begin
                    if (!bus.alarm_en) begin
                        state_q    <= IDLE;
                        snz_cnt_q  <= '0;
                        snoozing_q <= 1'b0;
                    end else if (bus.ack) begin
                        state_q    <= ARMED;
                        snz_cnt_q  <= '0;
                        snoozing_q <= 1'b0;
                    end else if (snz_cnt_q == SNZ_W'(SNOOZE_CYCLES - 1)) begin
                        state_q     <= RINGING;
                        snz_cnt_q   <= '0;
                        ring_cnt_q  <= '0;
                        snoozing_q  <= 1'b0;
                        alarm_on_q  <= 1'b1;
                        alarm_led_q <= 1'b1;
                    end else begin
                        snz_cnt_q <= snz_cnt_q + SNZ_W'(1);
                    end
                end
`endif
                default: begin
                    state_q     <= IDLE;
                    ring_cnt_q  <= '0;
                    alarm_on_q  <= 1'b0;
                    alarm_led_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.alarm_on  = alarm_on_q;
    assign bus.alarm_led = alarm_led_q;
`ifdef SNOOZE_EN
    assign bus.snoozing  = snoozing_q;
`else
    assign bus.snoozing  = 1'b0;
`endif

endmodule
